// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter.
// Holds the arbiter state encoding and the AXI response codes.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RRESP = 3'd4
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req (request vector), ptr (start index), idx (winner), valid.
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    int          j;
    logic [IW-1:0] j_idx;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int k = 0; k < NUM_M; k++) begin
            j     = (int'(ptr) + k) % NUM_M;
            j_idx = IW'(j);
            if (!valid && req[j_idx]) begin
                valid = 1'b1;
                idx   = j_idx;
            end
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave port among NUM_M requesters.
// Ports: S_* packed per-requester AXI-Lite buses (slice i = requester i),
//        M_* single AXI-Lite bus to the bridge, ACLK clock, ARESET sync reset.
module axil_rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_M      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_M*ADDRESS-1:0]    S_AWADDR,
    input  logic [NUM_M-1:0]            S_AWVALID,
    output logic [NUM_M-1:0]            S_AWREADY,
    input  logic [NUM_M*DATA_WIDTH-1:0] S_WDATA,
    input  logic [NUM_M*4-1:0]          S_WSTRB,
    input  logic [NUM_M-1:0]            S_WVALID,
    output logic [NUM_M-1:0]            S_WREADY,
    output logic [NUM_M*2-1:0]          S_BRESP,
    output logic [NUM_M-1:0]            S_BVALID,
    input  logic [NUM_M-1:0]            S_BREADY,
    input  logic [NUM_M*ADDRESS-1:0]    S_ARADDR,
    input  logic [NUM_M-1:0]            S_ARVALID,
    output logic [NUM_M-1:0]            S_ARREADY,
    output logic [NUM_M*DATA_WIDTH-1:0] S_RDATA,
    output logic [NUM_M*2-1:0]          S_RRESP,
    output logic [NUM_M-1:0]            S_RVALID,
    input  logic [NUM_M-1:0]            S_RREADY,
    output logic [ADDRESS-1:0]          M_AWADDR,
    output logic                        M_AWVALID,
    input  logic                        M_AWREADY,
    output logic [DATA_WIDTH-1:0]       M_WDATA,
    output logic [3:0]                  M_WSTRB,
    output logic                        M_WVALID,
    input  logic                        M_WREADY,
    input  logic [1:0]                  M_BRESP,
    input  logic                        M_BVALID,
    output logic                        M_BREADY,
    output logic [ADDRESS-1:0]          M_ARADDR,
    output logic                        M_ARVALID,
    input  logic                        M_ARREADY,
    input  logic [DATA_WIDTH-1:0]       M_RDATA,
    input  logic [1:0]                  M_RRESP,
    input  logic                        M_RVALID,
    output logic                        M_RREADY
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_e       state;
    logic [IW-1:0]    gnt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    ptr_nxt;
    logic             aw_done;
    logic             w_done;

    logic [NUM_M-1:0] wreq;
    logic [NUM_M-1:0] req;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             ar_hs;
    logic             r_hs;

    assign wreq = S_AWVALID & S_WVALID;
    assign req  = wreq | S_ARVALID;

    rr_pick #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID & M_WREADY;
    assign b_hs  = M_BVALID & M_BREADY;
    assign ar_hs = M_ARVALID & M_ARREADY;
    assign r_hs  = M_RVALID & M_RREADY;

    assign ptr_nxt = (int'(gnt) == NUM_M - 1) ? '0 : gnt + 1'b1;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            gnt     <= '0;
            rr_ptr  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt   <= pick_idx;
                        // A requester offering both directions gets its write first.
                        state <= wreq[pick_idx] ? WADDR : RADDR;
                    end
                end
                WADDR: begin
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WRESP;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        rr_ptr <= ptr_nxt;
                        state  <= IDLE;
                    end
                end
                RADDR: begin
                    if (ar_hs) state <= RRESP;
                end
                RRESP: begin
                    if (r_hs) begin
                        rr_ptr <= ptr_nxt;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the granted slice is ever driven; everything else stays 0.
    always_comb begin
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_ARREADY = '0;
        S_RVALID  = '0;
        S_BRESP   = {NUM_M{RESP_OKAY}};
        S_RRESP   = {NUM_M{RESP_OKAY}};
        S_RDATA   = '0;
        M_AWADDR  = '0;
        M_AWVALID = 1'b0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        M_ARADDR  = '0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (i == int'(gnt)) begin
                unique case (state)
                    WADDR: begin
                        // Done flags stop a completed channel from re-issuing.
                        M_AWVALID    = S_AWVALID[i] & ~aw_done;
                        M_WVALID     = S_WVALID[i] & ~w_done;
                        M_AWADDR     = S_AWADDR[i*ADDRESS +: ADDRESS];
                        M_WDATA      = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                        M_WSTRB      = S_WSTRB[i*4 +: 4];
                        S_AWREADY[i] = M_AWREADY & ~aw_done;
                        S_WREADY[i]  = M_WREADY & ~w_done;
                    end
                    WRESP: begin
                        S_BVALID[i]       = M_BVALID;
                        S_BRESP[i*2 +: 2] = M_BRESP;
                        M_BREADY          = S_BREADY[i];
                    end
                    RADDR: begin
                        M_ARVALID    = S_ARVALID[i];
                        M_ARADDR     = S_ARADDR[i*ADDRESS +: ADDRESS];
                        S_ARREADY[i] = M_ARREADY;
                    end
                    RRESP: begin
                        S_RVALID[i]                        = M_RVALID;
                        S_RRESP[i*2 +: 2]                  = M_RRESP;
                        S_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_RDATA;
                        M_RREADY                           = S_RREADY[i];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Testbench for axil_rr_arbiter: two requesters, a bridge model with
// programmable ready delays, and queue-based scoreboards on both sides.
module tb_axil_rr_arbiter;
    import axil_arb_pkg::*;

    localparam int NM = 2;

    logic          ACLK;
    logic          ARESET;
    logic [NM*32-1:0] S_AWADDR;
    logic [NM-1:0] S_AWVALID;
    logic [NM-1:0] S_AWREADY;
    logic [NM*32-1:0] S_WDATA;
    logic [NM*4-1:0] S_WSTRB;
    logic [NM-1:0] S_WVALID;
    logic [NM-1:0] S_WREADY;
    logic [NM*2-1:0] S_BRESP;
    logic [NM-1:0] S_BVALID;
    logic [NM-1:0] S_BREADY;
    logic [NM*32-1:0] S_ARADDR;
    logic [NM-1:0] S_ARVALID;
    logic [NM-1:0] S_ARREADY;
    logic [NM*32-1:0] S_RDATA;
    logic [NM*2-1:0] S_RRESP;
    logic [NM-1:0] S_RVALID;
    logic [NM-1:0] S_RREADY;
    logic [31:0]   M_AWADDR;
    logic          M_AWVALID;
    logic          M_AWREADY;
    logic [31:0]   M_WDATA;
    logic [3:0]    M_WSTRB;
    logic          M_WVALID;
    logic          M_WREADY;
    logic [1:0]    M_BRESP;
    logic          M_BVALID;
    logic          M_BREADY;
    logic [31:0]   M_ARADDR;
    logic          M_ARVALID;
    logic          M_ARREADY;
    logic [31:0]   M_RDATA;
    logic [1:0]    M_RRESP;
    logic          M_RVALID;
    logic          M_RREADY;

    axil_rr_arbiter #(.NUM_M(NM), .DATA_WIDTH(32), .ADDRESS(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
        .S_BREADY(S_BREADY), .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
        .M_BREADY(M_BREADY), .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID),
        .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mexp_t;

    typedef struct {
        int          idx;
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected handshake", nm);
    endtask

    function automatic void push_m(input bit wr, input logic [31:0] a,
                                   input logic [31:0] d);
        mexp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        mq.push_back(e);
    endfunction

    function automatic void push_r(input int i, input bit wr,
                                   input logic [1:0] rs, input logic [31:0] d);
        rexp_t e;
        e.idx = i; e.wr = wr; e.resp = rs; e.data = d;
        rq.push_back(e);
    endfunction

    // Bridge model: ready after a programmable number of valid cycles,
    // B/R returned one cycle after the address phase completes.
    int          aw_dly = 0;
    int          w_dly  = 0;
    int          awc, wc;
    bit          awg, wg, arg;
    logic [31:0] sa, sra;

    initial begin
        awc = 0; wc = 0; awg = 0; wg = 0; arg = 0; sa = '0; sra = '0;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
        M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
        forever begin
            @(posedge ACLK);
            if (ARESET) begin
                awc = 0; wc = 0; awg = 0; wg = 0; arg = 0;
            end else begin
                if (M_AWVALID && M_AWREADY) begin
                    awg = 1; sa = M_AWADDR;
                end else if (M_AWVALID) awc++;
                if (M_WVALID && M_WREADY) wg = 1;
                else if (M_WVALID) wc++;
                if (M_BVALID && M_BREADY) begin
                    awg = 0; wg = 0; awc = 0; wc = 0;
                end
                if (M_ARVALID && M_ARREADY) begin
                    arg = 1; sra = M_ARADDR;
                end
                if (M_RVALID && M_RREADY) arg = 0;
            end
            #2;
            M_AWREADY = !awg && (awc >= aw_dly);
            M_WREADY  = !wg && (wc >= w_dly);
            M_BVALID  = awg && wg;
            M_BRESP   = (sa == 32'h26) ? RESP_SLVERR : RESP_OKAY;
            M_ARREADY = !arg;
            M_RVALID  = arg;
            M_RDATA   = arg ? (32'hD000_0000 | sra) : 32'h0;
            M_RRESP   = RESP_OKAY;
        end
    end

    // Monitor: pops expectations as handshakes appear on either side.
    bit          cap_aw = 0;
    bit          cap_w  = 0;
    logic [31:0] cap_a;
    logic [31:0] cap_d;

    always @(negedge ACLK) begin
        mexp_t me;
        rexp_t re;
        logic [NM-1:0] own;
        if (ARESET) begin
            cap_aw = 0;
            cap_w  = 0;
        end else begin
            own = S_AWREADY | S_WREADY | S_ARREADY | S_BVALID | S_RVALID;
            if (own != '0) chk("one_owner", 64'($onehot(own)), 64'd1);
            if (cap_aw && !cap_w) chk("aw_reissue", M_AWVALID, 0);
            if (cap_w && !cap_aw) chk("w_reissue", M_WVALID, 0);
            if (M_AWVALID && M_AWREADY) begin
                cap_aw = 1; cap_a = M_AWADDR;
            end
            if (M_WVALID && M_WREADY) begin
                cap_w = 1; cap_d = M_WDATA;
            end
            if (cap_aw && cap_w) begin
                cap_aw = 0; cap_w = 0;
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_unexp_write: got addr %h, expected none", cap_a);
                end else begin
                    me = mq.pop_front();
                    chk("m_dir_w", 1, me.wr);
                    chk("m_awaddr", cap_a, me.addr);
                    chk("m_wdata", cap_d, me.data);
                end
            end
            if (M_ARVALID && M_ARREADY) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_unexp_read: got addr %h, expected none", M_ARADDR);
                end else begin
                    me = mq.pop_front();
                    chk("m_dir_r", 0, me.wr);
                    chk("m_araddr", M_ARADDR, me.addr);
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (S_BVALID[i] && S_BREADY[i]) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL s_unexp_b: got B on %0d, expected none", i);
                    end else begin
                        re = rq.pop_front();
                        chk("b_owner", i, re.idx);
                        chk("b_dir", 1, re.wr);
                        chk("bresp", S_BRESP[i*2 +: 2], re.resp);
                    end
                end
                if (S_RVALID[i] && S_RREADY[i]) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL s_unexp_r: got R on %0d, expected none", i);
                    end else begin
                        re = rq.pop_front();
                        chk("r_owner", i, re.idx);
                        chk("r_dir", 0, re.wr);
                        chk("rresp", S_RRESP[i*2 +: 2], re.resp);
                        chk("rdata", S_RDATA[i*32 +: 32], re.data);
                        for (int j = 0; j < NM; j++)
                            if (j != i) chk("r_route", S_RDATA[j*32 +: 32], 0);
                    end
                end
            end
        end
    end

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                      input bit wait_b);
        int n;
        bit awd, wd, bd;
        n = 0; awd = 0; wd = 0; bd = 0;
        S_AWADDR[i*32 +: 32] = a;
        S_WDATA[i*32 +: 32]  = d;
        S_WSTRB[i*4 +: 4]    = 4'hF;
        S_AWVALID[i] = 1'b1;
        S_WVALID[i]  = 1'b1;
        while (!(awd && wd) && n < 200) begin
            @(posedge ACLK);
            if (S_AWVALID[i] && S_AWREADY[i]) awd = 1;
            if (S_WVALID[i] && S_WREADY[i]) wd = 1;
            #1;
            if (awd) S_AWVALID[i] = 1'b0;
            if (wd) S_WVALID[i] = 1'b0;
            n++;
        end
        if (!(awd && wd)) begin
            tmo("wr_addr");
            S_AWVALID[i] = 1'b0;
            S_WVALID[i]  = 1'b0;
        end
        if (wait_b) begin
            while (!bd && n < 400) begin
                @(posedge ACLK);
                if (S_BVALID[i] && S_BREADY[i]) bd = 1;
                #1;
                n++;
            end
            if (!bd) tmo("wr_resp");
        end
    endtask

    task automatic rd(input int i, input logic [31:0] a);
        int n;
        bit ad, rdone;
        n = 0; ad = 0; rdone = 0;
        S_ARADDR[i*32 +: 32] = a;
        S_ARVALID[i] = 1'b1;
        while (!ad && n < 200) begin
            @(posedge ACLK);
            if (S_ARVALID[i] && S_ARREADY[i]) ad = 1;
            #1;
            if (ad) S_ARVALID[i] = 1'b0;
            n++;
        end
        if (!ad) begin
            tmo("rd_addr");
            S_ARVALID[i] = 1'b0;
        end
        while (!rdone && n < 400) begin
            @(posedge ACLK);
            if (S_RVALID[i] && S_RREADY[i]) rdone = 1;
            #1;
            n++;
        end
        if (!rdone) tmo("rd_resp");
    endtask

    task automatic chk_idle();
        chk("idle_s_hs", {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY,
                          S_RVALID, S_BRESP, S_RRESP}, 0);
        chk("idle_s_rdata", S_RDATA, 0);
        chk("idle_m_addr", {M_AWADDR, M_ARADDR}, 0);
        chk("idle_m_misc", {M_WDATA, M_WSTRB, M_AWVALID, M_WVALID,
                            M_BREADY, M_ARVALID, M_RREADY}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ARESET = 1'b1;
        S_AWADDR = '0; S_AWVALID = '0; S_WDATA = '0; S_WSTRB = '0;
        S_WVALID = '0; S_BREADY = '1; S_ARADDR = '0; S_ARVALID = '0;
        S_RREADY = '1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk_idle();
        @(posedge ACLK);
        #1 ARESET = 1'b0;

        // single write, forwarded one cycle after the request
        push_m(1, 32'h5, 32'hFACECAFE);
        push_r(0, 1, RESP_OKAY, 0);
        fork
            wr(0, 32'h5, 32'hFACECAFE, 1);
            begin
                @(posedge ACLK);
                @(negedge ACLK);
                chk("lat_awvalid", M_AWVALID, 1);
                chk("lat_awaddr", M_AWADDR, 32'h5);
                chk("lat_wdata", M_WDATA, 32'hFACECAFE);
                chk("lat_wstrb", M_WSTRB, 4'hF);
            end
        join

        // pointer now 1: simultaneous reads serve requester 1 first
        push_m(0, 32'h4, 0);
        push_m(0, 32'h3, 0);
        push_r(1, 0, RESP_OKAY, 32'hD000_0004);
        push_r(0, 0, RESP_OKAY, 32'hD000_0003);
        fork
            rd(0, 32'h3);
            rd(1, 32'h4);
        join

        // continuous reads alternate 1,0,1,0,1,0
        for (int k = 0; k < 3; k++) begin
            push_m(0, 32'h4, 0);
            push_m(0, 32'h3, 0);
            push_r(1, 0, RESP_OKAY, 32'hD000_0004);
            push_r(0, 0, RESP_OKAY, 32'hD000_0003);
        end
        fork
            begin repeat (3) rd(0, 32'h3); end
            begin repeat (3) rd(1, 32'h4); end
        join

        // contention after reset: requester 0 first
        ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        push_m(1, 32'h1, 32'h11111111);
        push_m(1, 32'h2, 32'h22222222);
        push_r(0, 1, RESP_OKAY, 0);
        push_r(1, 1, RESP_OKAY, 0);
        fork
            wr(0, 32'h1, 32'h11111111, 1);
            wr(1, 32'h2, 32'h22222222, 1);
        join

        // split writes, AW early then W early
        aw_dly = 0; w_dly = 3;
        push_m(1, 32'h7, 32'h77777777);
        push_r(0, 1, RESP_OKAY, 0);
        wr(0, 32'h7, 32'h77777777, 1);
        aw_dly = 3; w_dly = 0;
        push_m(1, 32'h8, 32'h88888888);
        push_r(1, 1, RESP_OKAY, 0);
        wr(1, 32'h8, 32'h88888888, 1);
        aw_dly = 0; w_dly = 0;

        // write wins over read on the same requester
        push_m(1, 32'h9, 32'h99999999);
        push_m(0, 32'hA, 0);
        push_r(1, 1, RESP_OKAY, 0);
        push_r(1, 0, RESP_OKAY, 32'hD000_000A);
        fork
            wr(1, 32'h9, 32'h99999999, 1);
            rd(1, 32'hA);
        join

        // SLVERR passthrough
        push_m(1, 32'h26, 32'hDEAD0026);
        push_r(0, 1, RESP_SLVERR, 0);
        wr(0, 32'h26, 32'hDEAD0026, 1);

        // reset while holding in WRESP, pointer is 1 beforehand
        S_BREADY[0] = 1'b0;
        push_m(1, 32'h30, 32'h33333333);
        wr(0, 32'h30, 32'h33333333, 0);
        n = 0;
        while (!S_BVALID[0] && n < 50) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        chk("rst_in_wresp", S_BVALID[0], 1);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk_idle();
        @(posedge ACLK);
        #1 S_BREADY[0] = 1'b1;
        push_m(0, 32'h40, 0);
        push_m(0, 32'h41, 0);
        push_r(0, 0, RESP_OKAY, 32'hD000_0040);
        push_r(1, 0, RESP_OKAY, 32'hD000_0041);
        fork
            rd(0, 32'h40);
            rd(1, 32'h41);
        join

        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        chk("mq_drained", mq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
